sim_bus_memory: RTL and testbench
=================================

Name: sim_bus_memory

Overview:
- Simulation memory model that serves both buses of the hkr_mips core in a unit-test bench.
- Instruction side: word-addressed ROM with a configurable wait-state handshake.
  - The bench preloads the ROM with $readmemh into the array named rom.
- Data side: byte-enabled RAM with combinational read and synchronous write.
- Replaces separate ROM and RAM stubs with one block that also checks the instruction-bus protocol.

Parameters:
- ROM_ADDR_BITS, 13: byte-address bits decoded on the instruction bus. ROM depth = 2^(ROM_ADDR_BITS-2) words.
- RAM_WORDS_LOG2, 16: log2 of RAM depth in 32-bit words.
- IBUS_WAIT_CYCLE, 4: extra clock edges each instruction read is stalled. 0 means zero-wait.

Ports:
- clk  in  1  single clock, all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- ibus_address  in  32  instruction byte address
- ibus_read  in  1  instruction read request
- ibus_rddata  out  32  instruction word
- ibus_stall  out  1  high while the read is not yet complete
- ibus_proto_err  out  1  sticky flag: instruction-bus protocol violation
- dbus_address  in  32  data byte address
- dbus_read  in  1  data read strobe
- dbus_write  in  1  data write strobe
- dbus_byteenable  in  4  byte lanes; bit n selects bits [8n+7:8n]
- dbus_wrdata  in  32  write data
- dbus_rddata  out  32  read data

Behaviour:
- Reset:
  - FSM goes to IDLE, wait counter = 0, ibus_stall = 0, ibus_proto_err = 0, ibus_rddata = 0.
  - Reset does not alter ROM or RAM contents.
- ROM indexing:
  - Word index = ibus_address[ROM_ADDR_BITS-1:2].
  - Upper address bits and bits [1:0] are ignored, so addresses wrap modulo the ROM size (e.g. 0x80000000 reads word 0).
- Instruction FSM, states IDLE / WAIT / DONE, for IBUS_WAIT_CYCLE > 0:
  - IDLE: if ibus_read=1, ibus_stall=1 combinationally in the same cycle. On the edge, latch the word index, set counter=1, go to WAIT.
  - WAIT: ibus_stall=1. Each edge increments the counter. When counter reaches IBUS_WAIT_CYCLE, on that edge register ibus_rddata = rom[latched index] and go to DONE.
  - DONE: ibus_stall=0 and ibus_rddata is valid; the CPU consumes it on this edge. Next state is IDLE, so a still-asserted ibus_read starts a new transaction with stall=1 in the following cycle.
  - Total stall = IBUS_WAIT_CYCLE+1 cycles, then one ready cycle.
- Instruction bus with IBUS_WAIT_CYCLE = 0:
  - ibus_stall is tied 0 and ibus_rddata = rom[index] combinationally. The FSM is unused.
- Protocol check:
  - In WAIT, a violation is ibus_read=0, or ibus_address different from the latched value.
  - A violation sets ibus_proto_err (sticky until rst), aborts the transaction and returns the FSM to IDLE.
- Reset mid-transaction: immediate return to IDLE with ibus_stall=0.
- RAM indexing:
  - Word index = dbus_address[RAM_WORDS_LOG2+1:2], wrapping modulo the depth.
  - dbus_address[1:0] is ignored; lanes are selected only by dbus_byteenable.
- RAM read:
  - dbus_rddata = ram[index] combinationally while dbus_read=1, else 0. No wait states.
  - Full word is returned regardless of byte enables; the CPU extracts lanes.
- RAM write: on the rising edge when dbus_write=1, update only the enabled byte lanes. dbus_byteenable=0 writes nothing.
- Simultaneous read and write of the same word: dbus_rddata shows the pre-write contents during that cycle and the new contents afterwards.
- Power-up contents: RAM initialises to 0 at time zero; ROM to 0 unless loaded by the bench.

Optional Feature:
- Macro: SIM_BUS_MEMORY_TRACE_EN.
- Defined: every RAM write edge prints "W addr=<word byte address hex> be=<bin> data=<merged word hex>". Every completed instruction fetch prints "F addr=<hex> data=<hex>".
- Undefined: no display statements are compiled; function is identical.

Test Plan:
- Zero-wait ROM read:
  - Setup: IBUS_WAIT_CYCLE=0, rom[0]=0x3C010001.
  - Stimulus: ibus_address=0x80000000, ibus_read=1.
  - Required: ibus_rddata=0x3C010001 in the same cycle, ibus_stall=0.
- Wait-state timing:
  - Setup: IBUS_WAIT_CYCLE=4, rom[1]=0x24210005.
  - Stimulus: hold ibus_read=1 at address 0x80000004.
  - Required: ibus_stall high for exactly 5 cycles, then low for 1 cycle with ibus_rddata=0x24210005, then high again.
- Protocol error:
  - Stimulus: deassert ibus_read in the second WAIT cycle.
  - Required: ibus_proto_err=1 and stays 1; FSM in IDLE; rst clears the flag.
- Byte-enable write:
  - Setup: ram word at 0x00000010 = 0x11223344.
  - Stimulus: write 0xAABBCCDD with be=4'b0101.
  - Required: readback 0x11BB33DD; be=4'b0000 leaves the word unchanged.
- Read/write collision:
  - Setup: same word holds 0x00000000.
  - Stimulus: read and write 0xFFFFFFFF with be=4'b1111 in one cycle.
  - Required: dbus_rddata=0 in that cycle, 0xFFFFFFFF in the next; dbus_read=0 gives 0.
- Reset mid-wait:
  - Stimulus: assert rst asynchronously during WAIT.
  - Required: ibus_stall drops immediately; RAM word 0x10 still reads its prior value.

Source files
------------

// File: rtl/sim_bus_memory_if.sv
// Instruction and data bus bundle between the hkr_mips core (master) and sim_bus_memory (slave).
interface sim_bus_memory_if;
  logic [31:0] ibus_address;
  logic        ibus_read;
  logic [31:0] ibus_rddata;
  logic        ibus_stall;
  logic        ibus_proto_err;
  logic [31:0] dbus_address;
  logic        dbus_read;
  logic        dbus_write;
  logic [3:0]  dbus_byteenable;
  logic [31:0] dbus_wrdata;
  logic [31:0] dbus_rddata;

  modport master (
    output ibus_address, ibus_read,
    input  ibus_rddata, ibus_stall, ibus_proto_err,
    output dbus_address, dbus_read, dbus_write, dbus_byteenable, dbus_wrdata,
    input  dbus_rddata
  );

  modport slave (
    input  ibus_address, ibus_read,
    output ibus_rddata, ibus_stall, ibus_proto_err,
    input  dbus_address, dbus_read, dbus_write, dbus_byteenable, dbus_wrdata,
    output dbus_rddata
  );
endinterface

// File: rtl/sim_bus_memory.sv
// Simulation memory for hkr_mips: wait-stated instruction ROM with protocol checking plus byte-enabled data RAM.
// Define SIM_BUS_MEMORY_TRACE_EN to print RAM writes and completed instruction fetches.
module sim_bus_memory #(
  parameter int unsigned ROM_ADDR_BITS   = 13,
  parameter int unsigned RAM_WORDS_LOG2  = 16,
  parameter int unsigned IBUS_WAIT_CYCLE = 4
) (
  input  logic             clk,
  input  logic             rst,
  sim_bus_memory_if.slave  bus
);
  localparam int unsigned ROM_WORDS = 1 << (ROM_ADDR_BITS - 2);
  localparam int unsigned RAM_WORDS = 1 << RAM_WORDS_LOG2;

  // ROM is filled by the bench through the hierarchical name rom; never written here
  logic [31:0] rom [ROM_WORDS] = '{default: '0};
  logic [31:0] ram [RAM_WORDS];

  logic [RAM_WORDS_LOG2-1:0] ram_idx;
  assign ram_idx = bus.dbus_address[RAM_WORDS_LOG2+1:2];

  // Combinational read shows pre-write contents during a same-cycle write
  assign bus.dbus_rddata = bus.dbus_read ? ram[ram_idx] : 32'h0;

  always_ff @(posedge clk) begin
    if (bus.dbus_write) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.dbus_byteenable[i]) ram[ram_idx][8*i +: 8] <= bus.dbus_wrdata[8*i +: 8];
      end
    end
  end

  wire unused_dbus = &{1'b0, bus.dbus_address[31:RAM_WORDS_LOG2+2], bus.dbus_address[1:0]};

`ifdef SIM_BUS_MEMORY_TRACE_EN
  logic [31:0] trace_merged;
  always_comb begin
    trace_merged = ram[ram_idx];
    for (int i = 0; i < 4; i++) begin
      if (bus.dbus_byteenable[i]) trace_merged[8*i +: 8] = bus.dbus_wrdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (bus.dbus_write)
      $display("W addr=%08h be=%04b data=%08h", {bus.dbus_address[31:2], 2'b00},
               bus.dbus_byteenable, trace_merged);
  end
`endif

  if (IBUS_WAIT_CYCLE == 0) begin : g_zero_wait
    assign bus.ibus_rddata    = rom[bus.ibus_address[ROM_ADDR_BITS-1:2]];
    assign bus.ibus_stall     = 1'b0;
    assign bus.ibus_proto_err = 1'b0;

    wire unused_ibus = &{1'b0, rst, bus.ibus_address[31:ROM_ADDR_BITS], bus.ibus_address[1:0]};

`ifdef SIM_BUS_MEMORY_TRACE_EN
    always_ff @(posedge clk) begin
      if (bus.ibus_read) $display("F addr=%08h data=%08h", bus.ibus_address, bus.ibus_rddata);
    end
`endif
  end else begin : g_wait_state
    localparam int unsigned CNT_W = $clog2(IBUS_WAIT_CYCLE + 1);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        rddata_q, rddata_d;
    logic               err_q, err_d;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q  <= IDLE;
        cnt_q    <= '0;
        addr_q   <= '0;
        rddata_q <= '0;
        err_q    <= 1'b0;
      end else begin
        state_q  <= state_d;
        cnt_q    <= cnt_d;
        addr_q   <= addr_d;
        rddata_q <= rddata_d;
        err_q    <= err_d;
      end
    end

    // A WAIT-state request change or drop aborts the fetch and latches the error
    always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      rddata_d = rddata_q;
      err_d    = err_q;
      unique case (state_q)
        IDLE: begin
          if (bus.ibus_read) begin
            addr_d  = bus.ibus_address;
            cnt_d   = CNT_W'(1);
            state_d = WAIT;
          end
        end
        WAIT: begin
          if (!bus.ibus_read || (bus.ibus_address != addr_q)) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else if (cnt_q == CNT_W'(IBUS_WAIT_CYCLE)) begin
            rddata_d = rom[addr_q[ROM_ADDR_BITS-1:2]];
            state_d  = DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    assign bus.ibus_stall     = !rst && (((state_q == IDLE) && bus.ibus_read) || (state_q == WAIT));
    assign bus.ibus_rddata    = rddata_q;
    assign bus.ibus_proto_err = err_q;

`ifdef SIM_BUS_MEMORY_TRACE_EN
    always_ff @(posedge clk) begin
      if (state_q == DONE) $display("F addr=%08h data=%08h", addr_q, rddata_q);
    end
`endif
  end
endmodule

// File: tb/tb_sim_bus_memory.sv
// Directed bench for sim_bus_memory: zero-wait and 4-wait instruction buses, protocol error, RAM lanes and collisions.
module tb_sim_bus_memory;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  sim_bus_memory_if mem_z_if ();
  sim_bus_memory_if mem_w_if ();

  sim_bus_memory #(.ROM_ADDR_BITS(13), .RAM_WORDS_LOG2(16), .IBUS_WAIT_CYCLE(0)) u_mem_z (
    .clk (clk),
    .rst (rst),
    .bus (mem_z_if.slave)
  );

  sim_bus_memory #(.ROM_ADDR_BITS(13), .RAM_WORDS_LOG2(16), .IBUS_WAIT_CYCLE(4)) u_mem_w (
    .clk (clk),
    .rst (rst),
    .bus (mem_w_if.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [6:0] exp_stall;

  initial begin
    mem_z_if.ibus_address = '0; mem_z_if.ibus_read = 1'b0;
    mem_z_if.dbus_address = '0; mem_z_if.dbus_read = 1'b0; mem_z_if.dbus_write = 1'b0;
    mem_z_if.dbus_byteenable = '0; mem_z_if.dbus_wrdata = '0;
    mem_w_if.ibus_address = '0; mem_w_if.ibus_read = 1'b0;
    mem_w_if.dbus_address = '0; mem_w_if.dbus_read = 1'b0; mem_w_if.dbus_write = 1'b0;
    mem_w_if.dbus_byteenable = '0; mem_w_if.dbus_wrdata = '0;
    exp_stall = 7'b1011111;

    #2;
    check("rst_stall", 32'(mem_w_if.ibus_stall), 32'h0);
    check("rst_err", 32'(mem_w_if.ibus_proto_err), 32'h0);
    check("rst_rddata", mem_w_if.ibus_rddata, 32'h0);

    u_mem_z.rom[0] = 32'h3C010001;
    u_mem_z.rom[1] = 32'h12345678;
    u_mem_w.rom[1] = 32'h24210005;
    u_mem_w.rom[2] = 32'hDEADBEEF;
    tick();
    rst = 1'b0;

    // zero-wait ROM: combinational data, address wraps modulo 8 KB
    mem_z_if.ibus_address = 32'h80000000;
    mem_z_if.ibus_read    = 1'b1;
    #1;
    check("zw_data0", mem_z_if.ibus_rddata, 32'h3C010001);
    check("zw_stall", 32'(mem_z_if.ibus_stall), 32'h0);
    mem_z_if.ibus_address = 32'h00002004;
    #1;
    check("zw_wrap", mem_z_if.ibus_rddata, 32'h12345678);
    mem_z_if.ibus_read = 1'b0;

    // wait-state timing: 5 stall cycles, 1 ready cycle, then stall again
    tick();
    mem_w_if.ibus_address = 32'h80000004;
    mem_w_if.ibus_read    = 1'b1;
    @(negedge clk);
    check("ws_stall_c0", 32'(mem_w_if.ibus_stall), 32'(exp_stall[0]));
    for (int k = 1; k < 7; k++) begin
      tick();
      @(negedge clk);
      check($sformatf("ws_stall_c%0d", k), 32'(mem_w_if.ibus_stall), 32'(exp_stall[k]));
      if (k == 5) check("ws_data", mem_w_if.ibus_rddata, 32'h24210005);
    end

    // protocol error: drop the request in the second WAIT cycle
    tick();
    @(negedge clk);
    check("pe_wait1_stall", 32'(mem_w_if.ibus_stall), 32'h1);
    tick();
    mem_w_if.ibus_read = 1'b0;
    @(negedge clk);
    check("pe_wait2_stall", 32'(mem_w_if.ibus_stall), 32'h1);
    check("pe_wait2_err", 32'(mem_w_if.ibus_proto_err), 32'h0);
    tick();
    @(negedge clk);
    check("pe_err_set", 32'(mem_w_if.ibus_proto_err), 32'h1);
    check("pe_idle_stall", 32'(mem_w_if.ibus_stall), 32'h0);
    tick();
    @(negedge clk);
    check("pe_err_sticky", 32'(mem_w_if.ibus_proto_err), 32'h1);
    check("pe_data_kept", mem_w_if.ibus_rddata, 32'h24210005);

    // byte-enable writes
    tick();
    mem_w_if.dbus_address = 32'h00000010; mem_w_if.dbus_wrdata = 32'h11223344;
    mem_w_if.dbus_byteenable = 4'b1111;   mem_w_if.dbus_write = 1'b1;
    tick();
    mem_w_if.dbus_write = 1'b0; mem_w_if.dbus_read = 1'b1;
    @(negedge clk);
    check("ram_init_word", mem_w_if.dbus_rddata, 32'h11223344);
    tick();
    mem_w_if.dbus_wrdata = 32'hAABBCCDD; mem_w_if.dbus_byteenable = 4'b0101; mem_w_if.dbus_write = 1'b1;
    tick();
    mem_w_if.dbus_write = 1'b0;
    @(negedge clk);
    check("ram_be0101", mem_w_if.dbus_rddata, 32'h11BB33DD);
    tick();
    mem_w_if.dbus_wrdata = 32'hFFFFFFFF; mem_w_if.dbus_byteenable = 4'b0000; mem_w_if.dbus_write = 1'b1;
    tick();
    mem_w_if.dbus_write = 1'b0;
    @(negedge clk);
    check("ram_be0000", mem_w_if.dbus_rddata, 32'h11BB33DD);
    mem_w_if.dbus_address = 32'h00040013;
    #1;
    check("ram_wrap", mem_w_if.dbus_rddata, 32'h11BB33DD);
    mem_w_if.dbus_read = 1'b0;
    #1;
    check("ram_noread", mem_w_if.dbus_rddata, 32'h0);

    // read/write collision on word 0x20
    tick();
    mem_w_if.dbus_address = 32'h00000020; mem_w_if.dbus_wrdata = 32'h0;
    mem_w_if.dbus_byteenable = 4'b1111;   mem_w_if.dbus_write = 1'b1;
    tick();
    mem_w_if.dbus_wrdata = 32'hFFFFFFFF; mem_w_if.dbus_read = 1'b1;
    @(negedge clk);
    check("coll_same", mem_w_if.dbus_rddata, 32'h0);
    tick();
    mem_w_if.dbus_write = 1'b0;
    @(negedge clk);
    check("coll_next", mem_w_if.dbus_rddata, 32'hFFFFFFFF);
    mem_w_if.dbus_read = 1'b0;
    #1;
    check("coll_noread", mem_w_if.dbus_rddata, 32'h0);

    // asynchronous reset during WAIT
    mem_w_if.dbus_address = 32'h00000010; mem_w_if.dbus_read = 1'b1;
    tick();
    mem_w_if.ibus_address = 32'h00000008; mem_w_if.ibus_read = 1'b1;
    tick();
    tick();
    #1;
    check("rw_stall_pre", 32'(mem_w_if.ibus_stall), 32'h1);
    rst = 1'b1;
    #1;
    check("rw_stall", 32'(mem_w_if.ibus_stall), 32'h0);
    check("rw_err_clr", 32'(mem_w_if.ibus_proto_err), 32'h0);
    check("rw_rddata", mem_w_if.ibus_rddata, 32'h0);
    check("rw_ram_kept", mem_w_if.dbus_rddata, 32'h11BB33DD);
    tick();
    rst = 1'b0;
    mem_w_if.ibus_read = 1'b0;
    mem_w_if.dbus_read = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
